// File: rtl/pzcorebus_store_forward_fifo_pkg.sv
// rtl/pzcorebus_store_forward_fifo_pkg.sv - shared types and helpers for the store-and-forward corebus buffer
package pzcorebus_store_forward_fifo_pkg;

  // Occupancy flags reported by each channel FIFO
  typedef struct packed {
    logic empty;
    logic full;
  } pzcorebus_sf_fifo_status;

  // Bit positions of the two channels in o_empty / o_full
  localparam int unsigned PZ_SF_CMD_IDX  = 0;
  localparam int unsigned PZ_SF_DATA_IDX = 1;

  // Pointer width that stays legal for a single-entry FIFO
  function automatic int unsigned pz_sf_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pzcorebus_store_forward_fifo_buf.sv
// rtl/pzcorebus_store_forward_fifo_buf.sv - single-channel FIFO with registered flags, one-cycle fill latency
module pzcorebus_store_forward_fifo_buf
  import pzcorebus_store_forward_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WIDTH-1:0]        i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_data,
  output pzcorebus_sf_fifo_status o_status
);

  localparam int unsigned PTR_W = pz_sf_ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A full FIFO refuses pushes even when a pop happens in the same cycle
  assign w_push   = i_valid && !r_full;
  assign w_pop    = i_ready && !r_empty;
  assign o_ready  = !r_full;
  assign o_valid  = !r_empty;
  assign o_data   = r_mem[r_rd_ptr];
  assign o_status.empty = r_empty;
  assign o_status.full  = r_full;

  // Storage array write; contents need no reset because flags gate visibility
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy count and registered empty/full flags
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + CNT_W'(1);
          r_empty <= 1'b0;
          r_full  <= (r_count == CNT_W'(DEPTH - 1));
        end
        2'b01: begin
          r_count <= r_count - CNT_W'(1);
          r_full  <= 1'b0;
          r_empty <= (r_count == CNT_W'(1));
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pzcorebus_store_forward_fifo.sv
// rtl/pzcorebus_store_forward_fifo.sv - corebus cmd/data buffer releasing write cmds only after whole bursts; burst overrun check under PZCOREBUS_STORE_FORWARD_FIFO_BURST_CHECK_EN
module pzcorebus_store_forward_fifo
  import pzcorebus_store_forward_fifo_pkg::*;
#(
  parameter int unsigned CMD_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned DATA_DEPTH    = 16,
  parameter bit          STORE_FORWARD = 1'b1,
  parameter int unsigned COUNT_WIDTH   = $clog2(CMD_DEPTH + DATA_DEPTH + 1)
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_mcmd_valid,
  output logic                   o_scmd_accept,
  input  logic [CMD_WIDTH-1:0]   i_mcmd,
  input  logic                   i_mcmd_has_data,
  output logic                   o_mcmd_valid,
  input  logic                   i_scmd_accept,
  output logic [CMD_WIDTH-1:0]   o_mcmd,
  output logic                   o_mcmd_has_data,
  input  logic                   i_mdata_valid,
  output logic                   o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]  i_mdata,
  input  logic                   i_mdata_last,
  output logic                   o_mdata_valid,
  input  logic                   i_sdata_accept,
  output logic [DATA_WIDTH-1:0]  o_mdata,
  output logic                   o_mdata_last,
  output logic [1:0]             o_empty,
  output logic [1:0]             o_full,
  output logic [COUNT_WIDTH-1:0] o_packet_count,
  output logic                   o_error
);

  pzcorebus_sf_fifo_status w_cmd_status;
  pzcorebus_sf_fifo_status w_data_status;
  logic [CMD_WIDTH:0]      w_cmd_head;
  logic                    w_cmd_fifo_valid;
  logic                    w_cmd_release;
  logic                    w_cmd_pop;
  logic                    w_data_push;
  logic                    w_packet_inc;
  logic                    w_packet_dec;
  logic [COUNT_WIDTH-1:0]  r_packet_count;

  pzcorebus_store_forward_fifo_buf #(
    .WIDTH (CMD_WIDTH + 1),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_valid  (i_mcmd_valid),
    .o_ready  (o_scmd_accept),
    .i_data   ({i_mcmd_has_data, i_mcmd}),
    .o_valid  (w_cmd_fifo_valid),
    .i_ready  (i_scmd_accept && w_cmd_release),
    .o_data   (w_cmd_head),
    .o_status (w_cmd_status)
  );

  pzcorebus_store_forward_fifo_buf #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_valid  (i_mdata_valid),
    .o_ready  (o_sdata_accept),
    .i_data   ({i_mdata_last, i_mdata}),
    .o_valid  (o_mdata_valid),
    .i_ready  (i_sdata_accept),
    .o_data   ({o_mdata_last, o_mdata}),
    .o_status (w_data_status)
  );

  // A write head waits for a stored complete burst; reads and cut-through pass freely
  assign w_cmd_release   = (STORE_FORWARD == 1'b0) || !w_cmd_head[CMD_WIDTH] ||
                           (r_packet_count != '0);
  assign o_mcmd_valid    = w_cmd_fifo_valid && w_cmd_release;
  assign o_mcmd          = w_cmd_head[CMD_WIDTH-1:0];
  assign o_mcmd_has_data = w_cmd_head[CMD_WIDTH];
  assign w_cmd_pop       = o_mcmd_valid && i_scmd_accept;
  assign w_data_push     = i_mdata_valid && o_sdata_accept;
  assign w_packet_inc    = w_data_push && i_mdata_last;
  assign w_packet_dec    = w_cmd_pop && o_mcmd_has_data;

  assign o_empty[PZ_SF_CMD_IDX]  = w_cmd_status.empty;
  assign o_empty[PZ_SF_DATA_IDX] = w_data_status.empty;
  assign o_full[PZ_SF_CMD_IDX]   = w_cmd_status.full;
  assign o_full[PZ_SF_DATA_IDX]  = w_data_status.full;
  assign o_packet_count          = r_packet_count;

  // Complete-packet counter; a cut-through write popped ahead of its data must not wrap it
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_packet_count <= '0;
    end else if (w_packet_inc && !w_packet_dec) begin
      r_packet_count <= r_packet_count + COUNT_WIDTH'(1);
    end else if (!w_packet_inc && w_packet_dec && (r_packet_count != '0)) begin
      r_packet_count <= r_packet_count - COUNT_WIDTH'(1);
    end
  end

`ifdef PZCOREBUS_STORE_FORWARD_FIFO_BURST_CHECK_EN
  localparam int unsigned BEAT_WIDTH = $clog2(DATA_DEPTH + 1);

  logic [BEAT_WIDTH-1:0] r_beat_count;
  logic                  r_error;

  // Beats of the incoming burst; a burst as deep as the data FIFO without last is an overrun
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_beat_count <= '0;
      r_error      <= 1'b0;
    end else if (w_data_push) begin
      if (i_mdata_last) begin
        r_beat_count <= '0;
      end else begin
        if (r_beat_count != BEAT_WIDTH'(DATA_DEPTH)) begin
          r_beat_count <= r_beat_count + BEAT_WIDTH'(1);
        end
        if (r_beat_count == BEAT_WIDTH'(DATA_DEPTH - 1)) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_pzcorebus_store_forward_fifo.sv
// tb/tb_pzcorebus_store_forward_fifo.sv - scoreboard bench for the store-and-forward corebus buffer
module tb_pzcorebus_store_forward_fifo;

  localparam int CW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear;
  logic          m_cmd_valid, s_cmd_accept, m_has_data;
  logic [CW-1:0] m_cmd;
  logic          d_cmd_valid, d_cmd_accept, d_has_data;
  logic [CW-1:0] d_cmd;
  logic          m_data_valid, s_data_accept, m_last;
  logic [DW-1:0] m_data;
  logic          d_data_valid, d_data_accept, d_last;
  logic [DW-1:0] d_data;
  logic [1:0]    empty, full;
  logic [4:0]    pcount;
  logic          error;

  logic          c_cmd_valid, c_s_accept, c_has_data, c_d_valid, c_d_accept, c_d_has_data;
  logic [7:0]    c_cmd, c_d_cmd;
  logic          c_data_valid, c_s_data_accept, c_last, c_d_data_valid, c_d_data_accept, c_d_last;
  logic [7:0]    c_data, c_d_data;
  logic [1:0]    c_empty, c_full;
  logic [2:0]    c_pcount;
  logic          c_error;

  pzcorebus_store_forward_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_mcmd_valid(m_cmd_valid), .o_scmd_accept(s_cmd_accept), .i_mcmd(m_cmd),
    .i_mcmd_has_data(m_has_data), .o_mcmd_valid(d_cmd_valid), .i_scmd_accept(d_cmd_accept),
    .o_mcmd(d_cmd), .o_mcmd_has_data(d_has_data),
    .i_mdata_valid(m_data_valid), .o_sdata_accept(s_data_accept), .i_mdata(m_data),
    .i_mdata_last(m_last), .o_mdata_valid(d_data_valid), .i_sdata_accept(d_data_accept),
    .o_mdata(d_data), .o_mdata_last(d_last),
    .o_empty(empty), .o_full(full), .o_packet_count(pcount), .o_error(error)
  );

  pzcorebus_store_forward_fifo #(
    .CMD_WIDTH(8), .DATA_WIDTH(8), .CMD_DEPTH(2), .DATA_DEPTH(4), .STORE_FORWARD(1'b0)
  ) dut_ct (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_mcmd_valid(c_cmd_valid), .o_scmd_accept(c_s_accept), .i_mcmd(c_cmd),
    .i_mcmd_has_data(c_has_data), .o_mcmd_valid(c_d_valid), .i_scmd_accept(c_d_accept),
    .o_mcmd(c_d_cmd), .o_mcmd_has_data(c_d_has_data),
    .i_mdata_valid(c_data_valid), .o_sdata_accept(c_s_data_accept), .i_mdata(c_data),
    .i_mdata_last(c_last), .o_mdata_valid(c_d_data_valid), .i_sdata_accept(c_d_data_accept),
    .o_mdata(c_d_data), .o_mdata_last(c_d_last),
    .o_empty(c_empty), .o_full(c_full), .o_packet_count(c_pcount), .o_error(c_error)
  );

  int total = 0;
  int bad   = 0;
  logic [CW:0] exp_cmd [$];
  logic [DW:0] exp_data [$];
  logic [CW:0] e_cmd;
  logic [DW:0] e_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [CW-1:0] c, input logic hd);
    m_cmd_valid = 1'b1;
    m_cmd       = c;
    m_has_data  = hd;
    exp_cmd.push_back({hd, c});
    tick();
    m_cmd_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic last);
    m_data_valid = 1'b1;
    m_data       = d;
    m_last       = last;
    exp_data.push_back({last, d});
    tick();
    m_data_valid = 1'b0;
  endtask

  // Output monitor: every completed downstream transfer is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && !clear) begin
      if (d_cmd_valid && d_cmd_accept) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", {d_has_data, d_cmd}, 128'hx);
        end else begin
          e_cmd = exp_cmd.pop_front();
          check("cmd_out", {d_has_data, d_cmd}, e_cmd);
        end
      end
      if (d_data_valid && d_data_accept) begin
        if (exp_data.size() == 0) begin
          check("data_unexpected", {d_last, d_data}, 128'hx);
        end else begin
          e_data = exp_data.pop_front();
          check("data_out", {d_last, d_data}, e_data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0;
    m_cmd_valid = 0; m_cmd = '0; m_has_data = 0; d_cmd_accept = 0;
    m_data_valid = 0; m_data = '0; m_last = 0; d_data_accept = 0;
    c_cmd_valid = 0; c_cmd = '0; c_has_data = 0; c_d_accept = 0;
    c_data_valid = 0; c_data = '0; c_last = 0; c_d_data_accept = 0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_empty", empty, 2'b11);
    check("rst_full", full, 2'b00);
    check("rst_count", pcount, 0);
    check("rst_error", error, 0);
    check("rst_accepts", {s_cmd_accept, s_data_accept}, 2'b11);

    // 2: store-and-forward write of a 4-beat burst
    d_cmd_accept = 1'b1; d_data_accept = 1'b1;
    push_cmd(32'hA000_0001, 1'b1);
    check("t2_gate_cmd", d_cmd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      push_beat({32'h1111_0000, 32'(i)}, i == 3);
      if (i < 3) check("t2_gate_beat", d_cmd_valid, 0);
    end
    check("t2_release", d_cmd_valid, 1);
    check("t2_count1", pcount, 1);
    tick();
    check("t2_count0", pcount, 0);
    check("t2_valid_off", d_cmd_valid, 0);

    // 3: read queued behind a pending write
    push_cmd(32'hB000_0002, 1'b1);
    push_cmd(32'hC000_0003, 1'b0);
    tick();
    check("t3_hold", d_cmd_valid, 0);
    push_beat(64'h2222_0000_0000_0000, 1'b0);
    check("t3_hold_beat", d_cmd_valid, 0);
    push_beat(64'h2222_0000_0000_0001, 1'b1);
    check("t3_release", {d_cmd_valid, d_has_data}, 2'b11);
    tick();
    check("t3_read_next", {d_cmd_valid, d_has_data}, 2'b10);
    tick();
    check("t3_cmd_empty", empty[0], 1);

    // 4: last-beat push and write-cmd pop in the same cycle
    d_cmd_accept = 1'b0;
    push_cmd(32'hD000_0004, 1'b1);
    push_cmd(32'hD000_0005, 1'b1);
    push_beat(64'h4444_0000_0000_0000, 1'b1);
    check("t4_count1", pcount, 1);
    check("t4_head_valid", d_cmd_valid, 1);
    d_cmd_accept = 1'b1;
    push_beat(64'h4444_0000_0000_0001, 1'b1);
    check("t4_same_cycle", pcount, 1);
    check("t4_second_valid", d_cmd_valid, 1);
    tick();
    check("t4_count0", pcount, 0);

    // 5: cut-through instance, write cmd without data
    c_cmd_valid = 1'b1; c_cmd = 8'h5A; c_has_data = 1'b1;
    tick();
    c_cmd_valid = 1'b0;
    check("t5_ct_valid", {c_d_valid, c_d_has_data, c_d_cmd}, {2'b11, 8'h5A});
    check("t5_ct_count", c_pcount, 0);
    c_d_accept = 1'b1;
    tick();
    c_d_accept = 1'b0;
    check("t5_no_underflow", c_pcount, 0);
    check("t5_ct_drained", {c_d_valid, c_empty[0]}, 2'b01);

    // 6: burst overrun, 16 beats without last into a stalled data channel
    repeat (3) tick();
    d_data_accept = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_beat({32'h6666_0000, 32'(i)}, 1'b0);
      if (i == 14) check("t6_no_error_15", error, 0);
    end
`ifdef PZCOREBUS_STORE_FORWARD_FIFO_BURST_CHECK_EN
    check("t6_error_set", error, 1);
`else
    check("t6_error_tied", error, 0);
`endif
    check("t6_data_full", {full[1], s_data_accept}, 2'b10);
    repeat (3) tick();
`ifdef PZCOREBUS_STORE_FORWARD_FIFO_BURST_CHECK_EN
    check("t6_error_sticky", error, 1);
`else
    check("t6_error_sticky", error, 0);
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_data.delete();
    check("t6_clear_error", error, 0);
    check("t6_clear_empty", empty, 2'b11);
    check("t6_clear_full", full, 2'b00);
    check("t6_clear_count", pcount, 0);

    repeat (2) tick();
    check("cmd_scoreboard_drained", exp_cmd.size(), 0);
    check("data_scoreboard_drained", exp_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
